// File: rtl/crc_feeder_pkg.sv
// Shared definitions for the CRC feeder: register maps, status bit positions, FSM states.
package crc_feeder_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_RESULT = 2'd3;

   localparam logic [1:0] M_ADDR_DATA   = 2'd0;
   localparam logic [1:0] M_ADDR_RESULT = 2'd1;

   localparam int CTRL_GO  = 0;
   localparam int CTRL_CLR = 1;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_DONE  = 3;
   localparam int ST_OVF   = 4;
   localparam int ST_COUNT = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_RD_REQ,
      S_RD_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/crc_feeder_fifo.sv
// First-word-fallthrough word FIFO; a push while full is accepted only if a pop happens in the same cycle.
module crc_feeder_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/crc_feeder.sv
// CPU-side word buffer that streams queued words into a CRC slave, then fetches the result.
// Optional build macro CRC_FEEDER_BYTESWAP_EN byte-reverses each forwarded word.
module crc_feeder
   import crc_feeder_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        s_address,
   input  logic              s_read,
   input  logic              s_write,
   input  logic              s_chipselect,
   input  logic [DATA_W-1:0] s_writedata,
   output logic [DATA_W-1:0] s_readdata,
   output logic [1:0]        m_address,
   output logic              m_read,
   output logic              m_write,
   output logic              m_chipselect,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   logic [DATA_W-1:0] result;
   logic              done_flag;
   logic              ovf;

   logic              wr_acc;
   logic              rd_acc;
   logic              push;
   logic              pop;
   logic              go;
   logic              clr;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] status_word;

   function automatic logic [DATA_W-1:0] fmt_word(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
`ifdef CRC_FEEDER_BYTESWAP_EN
      for (int i = 0; i < DATA_W / 8; i++) begin
         r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
      end
`else
      r = w;
`endif
      return r;
   endfunction

   assign wr_acc = s_chipselect && s_write;
   assign rd_acc = s_chipselect && s_read;
   assign push   = wr_acc && (s_address == REG_DATA);
   assign go     = wr_acc && (s_address == REG_CTRL) && s_writedata[CTRL_GO];
   assign clr    = wr_acc && (s_address == REG_CTRL) && s_writedata[CTRL_CLR];
   assign pop    = (state == S_PUSH) && !empty;

   crc_feeder_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .CW     (CW)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (s_writedata),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      status_word                    = '0;
      status_word[ST_COUNT +: 8]     = 8'(count);
      status_word[ST_OVF]            = ovf;
      status_word[ST_DONE]           = done_flag;
      status_word[ST_EMPTY]          = empty;
      status_word[ST_FULL]           = full;
      status_word[ST_BUSY]           = (state != S_IDLE);
   end

   // Master strobes are registered: each reflects the state decision taken on the previous edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         m_address    <= M_ADDR_DATA;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_chipselect <= 1'b0;
         m_writedata  <= '0;
         result       <= '0;
         done_flag    <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         m_address    <= M_ADDR_DATA;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_chipselect <= 1'b0;
         if (clr) begin
            done_flag <= 1'b0;
            ovf       <= 1'b0;
         end
         if (push && full && !pop) ovf <= 1'b1;
         case (state)
            S_IDLE: begin
               if (go) begin
                  if (empty) begin
                     state        <= S_RD_REQ;
                     m_read       <= 1'b1;
                     m_chipselect <= 1'b1;
                     m_address    <= M_ADDR_RESULT;
                  end else begin
                     state <= S_PUSH;
                  end
               end
            end
            S_PUSH: begin
               if (!empty) begin
                  m_write      <= 1'b1;
                  m_chipselect <= 1'b1;
                  m_writedata  <= fmt_word(head);
               end else begin
                  state        <= S_RD_REQ;
                  m_read       <= 1'b1;
                  m_chipselect <= 1'b1;
                  m_address    <= M_ADDR_RESULT;
               end
            end
            S_RD_REQ: begin
               state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               result <= m_readdata;
               state  <= S_DONE;
            end
            S_DONE: begin
               done_flag <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_readdata <= '0;
      end else if (rd_acc) begin
         case (s_address)
            REG_STATUS: s_readdata <= status_word;
            REG_RESULT: s_readdata <= result;
            default:    s_readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_feeder.sv
// Directed self-checking bench for crc_feeder with a registered-response CRC slave stub.
module tb_crc_feeder;

   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [1:0]        s_address = '0;
   logic              s_read = 1'b0;
   logic              s_write = 1'b0;
   logic              s_chipselect = 1'b0;
   logic [DATA_W-1:0] s_writedata = '0;
   logic [DATA_W-1:0] s_readdata;
   logic [1:0]        m_address;
   logic              m_read;
   logic              m_write;
   logic              m_chipselect;
   logic [DATA_W-1:0] m_writedata;
   logic [DATA_W-1:0] m_readdata = '0;

   logic [DATA_W-1:0] stub_val = 32'hDEADBEEF;
   int                n_cmp = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                n_rd = 0;
   int                bad_strobe = 0;
   logic [DATA_W-1:0] wr_q[$];
   int                wr_cyc[$];

   always #5 clk = ~clk;

   crc_feeder #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_read       (s_read),
      .s_write      (s_write),
      .s_chipselect (s_chipselect),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_read       (m_read),
      .m_write      (m_write),
      .m_chipselect (m_chipselect),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata)
   );

   // CRC slave stub: result is valid only in the cycle right after m_read.
   always @(posedge clk) begin
      m_readdata <= m_read ? stub_val : '0;
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (m_write) begin
         wr_q.push_back(m_writedata);
         wr_cyc.push_back(cyc);
         if (m_address != 2'd0 || !m_chipselect) bad_strobe = bad_strobe + 1;
      end
      if (m_read) begin
         n_rd = n_rd + 1;
         if (m_address != 2'd1 || !m_chipselect) bad_strobe = bad_strobe + 1;
      end
      if (m_write && m_read) bad_strobe = bad_strobe + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      s_address = a; s_writedata = d; s_write = 1'b1; s_chipselect = 1'b1;
      @(negedge clk);
      s_write = 1'b0; s_chipselect = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      s_address = a; s_read = 1'b1; s_chipselect = 1'b1;
      @(negedge clk);
      s_read = 1'b0; s_chipselect = 1'b0;
      d = s_readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] exp_fmt(input logic [31:0] w);
`ifdef CRC_FEEDER_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   initial begin
      logic [31:0] rd;
      logic [31:0] words [3];
      logic [31:0] exp_words [3];
      int          base;
      int          rd_base;
      int          bad_base;
      logic        found;

      words = '{32'h0e1b2c54, 32'h05438245, 32'h05340543};
`ifdef CRC_FEEDER_BYTESWAP_EN
      exp_words = '{32'h542c1b0e, 32'h45824305, 32'h43053405};
`else
      exp_words = '{32'h0e1b2c54, 32'h05438245, 32'h05340543};
`endif

      // Reset state
      idle(3);
      check("rst_m_write", {31'd0, m_write}, 32'd0);
      check("rst_m_read", {31'd0, m_read}, 32'd0);
      check("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
      check("rst_readdata", s_readdata, 32'd0);
      reset_n = 1'b1;
      bus_read(2'd2, rd); check("rst_status", rd, 32'h00000004);
      bus_read(2'd3, rd); check("rst_result", rd, 32'h00000000);

      // Three-word run
      base = wr_q.size(); rd_base = n_rd; bad_base = bad_strobe;
      for (int i = 0; i < 3; i++) bus_write(2'd0, words[i]);
      bus_read(2'd2, rd); check("three_status_pre", rd, 32'h00000300);
      bus_write(2'd1, 32'h1);
      idle(15);
      check("three_nwr", wr_q.size() - base, 3);
      for (int i = 0; i < 3; i++) begin
         if (wr_q.size() > base + i) check($sformatf("three_word%0d", i), wr_q[base+i], exp_words[i]);
         else check($sformatf("three_word%0d", i), 32'hxxxxxxxx, exp_words[i]);
      end
      if (wr_q.size() >= base + 3) check("three_back2back", wr_cyc[base+2] - wr_cyc[base], 2);
      check("three_nrd", n_rd - rd_base, 1);
      check("three_strobes", bad_strobe - bad_base, 0);
      bus_read(2'd3, rd); check("three_result", rd, 32'hDEADBEEF);
      bus_read(2'd2, rd); check("three_status", rd, 32'h0000000C);
      bus_read(2'd0, rd); check("rd_data_reg", rd, 32'h0);
      bus_read(2'd1, rd); check("rd_ctrl_reg", rd, 32'h0);

      // Overflow run
      bus_write(2'd1, 32'h2);
      bus_read(2'd2, rd); check("clr_status", rd, 32'h00000004);
      base = wr_q.size(); rd_base = n_rd;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) bus_write(2'd0, 32'h100 + i);
      bus_read(2'd2, rd); check("ovf_status_pre", rd, 32'h00000812);
      bus_write(2'd1, 32'h1);
      idle(25);
      check("ovf_nwr", wr_q.size() - base, 8);
      if (wr_q.size() >= base + 8) begin
         check("ovf_first", wr_q[base], exp_fmt(32'h100));
         check("ovf_last", wr_q[base+7], exp_fmt(32'h107));
      end
      check("ovf_nrd", n_rd - rd_base, 1);
      bus_read(2'd2, rd); check("ovf_status_post", rd, 32'h0000001C);
      bus_write(2'd1, 32'h2);
      bus_read(2'd2, rd); check("ovf_clr_status", rd, 32'h00000004);

      // GO with empty FIFO
      stub_val = 32'h12345678;
      base = wr_q.size(); rd_base = n_rd;
      bus_write(2'd1, 32'h1);
      idle(3);
      bus_read(2'd2, rd); check("empty_go_status", rd, 32'h0000000C);
      check("empty_go_nwr", wr_q.size() - base, 0);
      check("empty_go_nrd", n_rd - rd_base, 1);
      bus_read(2'd3, rd); check("empty_go_result", rd, 32'h12345678);

      // Reset during PUSH
      bus_write(2'd1, 32'h2);
      base = wr_q.size(); rd_base = n_rd;
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hA0 + i);
      bus_write(2'd1, 32'h1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (wr_q.size() - base == 2) found = 1'b1;
      end
      check("midrst_reach", {31'd0, found}, 32'd1);
      check("midrst_pre_wr", {31'd0, m_write}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_m_write", {31'd0, m_write}, 32'd0);
      check("midrst_m_cs", {31'd0, m_chipselect}, 32'd0);
      check("midrst_m_read", {31'd0, m_read}, 32'd0);
      idle(2);
      reset_n = 1'b1;
      idle(10);
      check("midrst_nwr", wr_q.size() - base, 2);
      check("midrst_nrd", n_rd - rd_base, 0);
      bus_read(2'd2, rd); check("midrst_status", rd, 32'h00000004);
      bus_read(2'd3, rd); check("midrst_result", rd, 32'h0);

      // Single-word formatting
      base = wr_q.size();
      bus_write(2'd0, 32'h00ebd51b);
      bus_write(2'd1, 32'h1);
      idle(10);
      check("fmt_nwr", wr_q.size() - base, 1);
`ifdef CRC_FEEDER_BYTESWAP_EN
      if (wr_q.size() > base) check("fmt_word", wr_q[base], 32'h1bd5eb00);
`else
      if (wr_q.size() > base) check("fmt_word", wr_q[base], 32'h00ebd51b);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/crc_feeder.md
CRC_FEEDER -- requirements
Module: crc_feeder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the word FIFO depth (power of two, 2..64).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width on both buses.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 s_address  in  2  CPU-side slave register select: 0 DATA, 1 CTRL, 2 STATUS, 3 RESULT.
REQ-006 s_read, s_write, s_chipselect  in  1 each  slave strobes; an access is valid only with s_chipselect=1.
REQ-007 s_writedata  in  DATA_W  slave write data.
REQ-008 s_readdata  out  DATA_W  slave read data, registered, valid one cycle after s_read.
REQ-009 m_address  out  2  master address to the downstream CRC slave: 0 data word, 1 result.
REQ-010 m_read, m_write, m_chipselect  out  1 each  master strobes to the CRC slave.
REQ-011 m_writedata  out  DATA_W  word forwarded to the CRC slave.
REQ-012 m_readdata  in  DATA_W  CRC result, sampled exactly one cycle after m_read.

Function
REQ-013 A slave write to DATA SHALL push s_writedata into the FIFO; when the FIFO is full, the word SHALL be dropped and sticky OVF set.
REQ-014 A slave write to CTRL with bit0=1 (GO) SHALL arm the FSM; bit1=1 SHALL clear DONE and OVF; both bits may be written together.
REQ-015 FSM states SHALL be IDLE, PUSH, RD_REQ, RD_WAIT, DONE.
REQ-016 IDLE->PUSH on GO; PUSH SHALL issue one m_write (m_address=0, m_chipselect=1) per cycle while the FIFO is non-empty, popping one word each.
REQ-017 PUSH->RD_REQ on the cycle after the FIFO becomes empty; RD_REQ SHALL assert m_read, m_chipselect, m_address=1 for exactly one cycle, then enter RD_WAIT.
REQ-018 RD_WAIT SHALL capture m_readdata into RESULT and go to DONE; DONE SHALL set the DONE status bit and return to IDLE next cycle.
REQ-019 A word pushed at slave cycle N SHALL appear on m_writedata no earlier than cycle N+1; words SHALL be forwarded in FIFO order.
REQ-020 DATA writes during PUSH SHALL be accepted and forwarded in the same run; writes during RD_REQ/RD_WAIT/DONE SHALL be queued for the next GO.
REQ-021 GO while not IDLE SHALL be ignored; GO with an empty FIFO SHALL go directly to RD_REQ.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged and be legal when full.
REQ-023 STATUS SHALL read {count[7:0] in bits 15:8, OVF bit4, DONE bit3, EMPTY bit2, FULL bit1, BUSY bit0}, other bits zero; BUSY=1 in any state except IDLE.
REQ-024 Slave reads of DATA and CTRL SHALL return zero; m_* strobes SHALL be 0 outside their state.

Reset
REQ-025 On reset_n=0, asynchronously: FSM=IDLE, FIFO empty, count=0, RESULT=0, DONE=0, OVF=0, all m_* outputs 0, s_readdata=0.
REQ-026 Reset mid-run SHALL abandon the run with no further master strobes; FIFO contents SHALL be lost.

Configuration
REQ-027 With CRC_FEEDER_BYTESWAP_EN defined, m_writedata SHALL be the byte-reversed FIFO word (0x0e1b2c54 -> 0x542c1b0e); without it, words SHALL be forwarded unchanged.

Structure
REQ-028 The shared package SHALL hold the slave register offsets, master offsets (DATA=0, RESULT=1), STATUS bit positions and the FSM state enumeration.
REQ-029 The FIFO SHALL be a sub-module named crc_feeder_fifo with push/pop/full/empty/count ports.

Verification
REQ-030 Reset, then read STATUS -> 0x00000004 (EMPTY only).
REQ-031 Push 0x0e1b2c54, 0x05438245, 0x05340543, then GO -> three consecutive m_write cycles with those words in order; one m_read at address 1; stub m_readdata=0xDEADBEEF -> RESULT=0xDEADBEEF, STATUS DONE=1, BUSY=0.
REQ-032 Push FIFO_DEPTH+1 words -> count=8, FULL=1, OVF=1; after GO exactly 8 m_write cycles; CTRL write 0x2 clears OVF and DONE.
REQ-033 GO with empty FIFO -> no m_write, one m_read, DONE=1 within 4 cycles.
REQ-034 Assert reset_n=0 during PUSH after 2 of 5 words -> strobes drop immediately; STATUS=0x00000004 after release.
REQ-035 With CRC_FEEDER_BYTESWAP_EN: push 0x00ebd51b, GO -> m_writedata=0x1bd5eb00.
